// File: rtl/data_sram_bridge_pkg.sv
// Shared definitions for the data SRAM bridge: transfer-size encodings,
// FSM state encoding and the alignment helper.
package data_sram_bridge_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } bridgeState_t;

    // Size 2'b11 falls into the default branch and is checked as a word.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addrLo[0];
            default: bad = (addrLo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_sram_bridge_load_align.sv
// Load-data extraction: picks the addressed byte/half out of the bus word
// and sign- or zero-extends it to 32 bits.
module load_align
    import data_sram_bridge_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        isSigned,
    output logic [31:0] result
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        case (addr)
            2'd0:    byteSel = rdata[7:0];
            2'd1:    byteSel = rdata[15:8];
            2'd2:    byteSel = rdata[23:16];
            default: byteSel = rdata[31:24];
        endcase
        halfSel = addr[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: result = {{24{isSigned & byteSel[7]}}, byteSel};
            SZ_HALF: result = {{16{isSigned & halfSel[15]}}, halfSel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/data_sram_bridge.sv
// Bridges the M-stage load/store port onto an addr_ok/data_ok SRAM-style bus,
// stalling the pipeline until the transfer completes.
//
// state | meaning
// IDLE  | no access in flight; an aligned mem_enM issues the request at once
// REQ   | request presented, waiting for addr_ok
// WAIT  | address accepted, waiting for data_ok
// DONE  | one-cycle completion: stall released, load data presented
module data_sram_bridge
    import data_sram_bridge_pkg::*;
#(
    parameter bit KSEG_MAP = 1'b1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_enM,
    input  logic        memwriteM,
    input  logic [1:0]  mem_sizeM,
    input  logic        mem_signedM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        addr_errM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    bridgeState_t stateQ, stateNext;
    logic [31:0]  capturedData;
    logic [31:0]  alignedData;
    logic [31:0]  physAddr;
    logic [31:0]  laneData;
    logic [3:0]   laneStrb;
    logic [1:0]   busSize;
    logic         misaligned;
    logic         reqActive;
    logic         captureEn;

    assign misaligned = isMisaligned(mem_sizeM, aluoutM[1:0]);
    assign addr_errM  = mem_enM & misaligned & (stateQ == IDLE);
    assign readdataM  = capturedData;

    // kseg0/kseg1 both alias the low 512 MB of physical space.
    always_comb begin
        physAddr = aluoutM;
        if (KSEG_MAP && aluoutM[31:30] == 2'b10)
            physAddr = {3'b000, aluoutM[28:0]};
    end

    always_comb begin
        busSize  = SZ_WORD;
        laneStrb = 4'b1111;
        laneData = writedataM;
        case (mem_sizeM)
            SZ_BYTE: begin
                busSize  = SZ_BYTE;
                laneStrb = 4'b0001 << aluoutM[1:0];
                laneData = {4{writedataM[7:0]}};
            end
            SZ_HALF: begin
                busSize  = SZ_HALF;
                laneStrb = aluoutM[1] ? 4'b1100 : 4'b0011;
                laneData = {2{writedataM[15:0]}};
            end
            default: ;
        endcase
        if (!memwriteM)
            laneStrb = 4'b0000;
    end

    always_comb begin
        stateNext = stateQ;
        reqActive = 1'b0;
        stallM    = 1'b0;
        case (stateQ)
            IDLE, REQ: begin
                if (stateQ == REQ || (mem_enM && !misaligned)) begin
                    reqActive = 1'b1;
                    stallM    = 1'b1;
                    if (data_addr_ok && data_data_ok)
                        stateNext = DONE;
                    else if (data_addr_ok)
                        stateNext = WAIT;
                    else
                        stateNext = REQ;
                end
            end
            WAIT: begin
                stallM = 1'b1;
                if (data_data_ok)
                    stateNext = DONE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Entering DONE only happens on a legitimate completion, so stray data_ok is never captured.
    assign captureEn = (stateNext == DONE) && (stateQ != DONE) && !memwriteM;

    assign data_req   = reqActive;
    assign data_wr    = reqActive & memwriteM;
    assign data_size  = reqActive ? busSize  : 2'b00;
    assign data_addr  = reqActive ? physAddr : 32'h0;
    assign data_wstrb = reqActive ? laneStrb : 4'b0000;
    assign data_wdata = reqActive ? laneData : 32'h0;

    load_align uLoadAlign (
        .rdata    (data_rdata),
        .addr     (aluoutM[1:0]),
        .size     (mem_sizeM),
        .isSigned (mem_signedM),
        .result   (alignedData)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            stateQ       <= IDLE;
            capturedData <= 32'h0;
        end else begin
            stateQ <= stateNext;
            if (captureEn)
                capturedData <= alignedData;
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed self-checking bench for data_sram_bridge; expected load results
// go through a scoreboard queue and are popped when the access completes.
module tb_data_sram_bridge;

    logic        clk;
    logic        rst;
    logic        mem_enM;
    logic        memwriteM;
    logic [1:0]  mem_sizeM;
    logic        mem_signedM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic        stallM;
    logic        addr_errM;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] sbQ[$];

    data_sram_bridge #(.KSEG_MAP(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_enM      (mem_enM),
        .memwriteM    (memwriteM),
        .mem_sizeM    (mem_sizeM),
        .mem_signedM  (mem_signedM),
        .aluoutM      (aluoutM),
        .writedataM   (writedataM),
        .readdataM    (readdataM),
        .stallM       (stallM),
        .addr_errM    (addr_errM),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idleInputs();
        mem_enM      = 1'b0;
        memwriteM    = 1'b0;
        mem_sizeM    = 2'b00;
        mem_signedM  = 1'b0;
        aluoutM      = 32'h0;
        writedataM   = 32'h0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
    endtask

    // One full access. addr_ok arrives aDly cycles after the first request
    // cycle, data_ok dDly cycles after addr_ok. Called just after a negedge.
    task automatic doAccess(input string tag, input logic wr, input logic [1:0] sz,
                            input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int aDly, input int dDly,
                            input logic [31:0] expAddr, input logic [1:0] expSize,
                            input logic [3:0] expStrb, input logic [31:0] expWdata,
                            input logic [31:0] expRead, input int expStall, input int expReq);
        int  cyc = 0;
        int  stallCnt = 0;
        int  reqCnt = 0;
        bit  done = 0;
        logic [31:0] expVal;
        mem_enM     = 1'b1;
        memwriteM   = wr;
        mem_sizeM   = sz;
        mem_signedM = sgn;
        aluoutM     = addr;
        writedataM  = wd;
        data_rdata  = rd;
        if (!wr) sbQ.push_back(expRead);
        while (!done && cyc < 64) begin
            data_addr_ok = (cyc == aDly);
            data_data_ok = (cyc == aDly + dDly);
            #1;
            if (data_req) begin
                reqCnt++;
                check({tag, "_addr"}, data_addr, expAddr);
                check({tag, "_strb"}, {28'h0, data_wstrb}, {28'h0, expStrb});
                if (reqCnt == 1) begin
                    check({tag, "_wr"}, {31'h0, data_wr}, {31'h0, wr});
                    check({tag, "_size"}, {30'h0, data_size}, {30'h0, expSize});
                    if (wr) check({tag, "_wdata"}, data_wdata, expWdata);
                end
            end
            if (stallM) stallCnt++;
            else done = 1;
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout: observed stall after %0d cycles expected release", tag, cyc);
        end
        check({tag, "_stall"}, stallCnt, expStall);
        check({tag, "_reqcyc"}, reqCnt, expReq);
        if (!wr) begin
            if (sbQ.size() > 0) begin
                expVal = sbQ.pop_front();
                check({tag, "_rdata"}, readdataM, expVal);
            end else begin
                checks++;
                errors++;
                $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
            end
        end
        @(negedge clk);
        idleInputs();
        #1;
        check({tag, "_idle_stall"}, {31'h0, stallM}, 32'h0);
        check({tag, "_idle_req"}, {31'h0, data_req}, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        idleInputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", {31'h0, data_req}, 32'h0);
        check("rst_stall", {31'h0, stallM}, 32'h0);
        check("rst_aerr", {31'h0, addr_errM}, 32'h0);
        check("rst_rdata", readdataM, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        //        tag       wr    sz     sgn   addr          wd            rd            aD dD expAddr       sz     strb     wdata         read          st rq
        doAccess("wload",  1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0,        32'h1234_5678, 0, 0, 32'h0000_0010, 2'b10, 4'b0000, 32'h0,        32'h1234_5678, 1, 1);
        doAccess("lbs",    1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 1, 1, 32'h0000_0103, 2'b00, 4'b0000, 32'h0,        32'hFFFF_FF80, 3, 2);
        doAccess("lbu",    1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 0, 0, 32'h0000_0103, 2'b00, 4'b0000, 32'h0,        32'h0000_0080, 1, 1);
        doAccess("sh",     1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h0,        3, 2, 32'h0000_0202, 2'b01, 4'b1100, 32'hABCD_ABCD, 32'h0,        6, 4);
        doAccess("sb",     1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h1234_565A, 32'h0,        0, 0, 32'h0000_0001, 2'b00, 4'b0010, 32'h5A5A_5A5A, 32'h0,        1, 1);
        doAccess("sw",     1'b1, 2'b10, 1'b0, 32'hA000_0004, 32'hDEAD_BEEF, 32'h0,        0, 1, 32'h0000_0004, 2'b10, 4'b1111, 32'hDEAD_BEEF, 32'h0,        2, 1);
        doAccess("lhs",    1'b0, 2'b01, 1'b1, 32'h0000_0042, 32'h0,        32'h8001_7FFF, 2, 0, 32'h0000_0042, 2'b01, 4'b0000, 32'h0,        32'hFFFF_8001, 3, 3);
        doAccess("lhu",    1'b0, 2'b01, 1'b0, 32'h0000_0040, 32'h0,        32'h8001_FFFF, 0, 0, 32'h0000_0040, 2'b01, 4'b0000, 32'h0,        32'h0000_FFFF, 1, 1);
        doAccess("kseg2",  1'b0, 2'b10, 1'b0, 32'hC000_0008, 32'h0,        32'hCAFE_F00D, 0, 0, 32'hC000_0008, 2'b10, 4'b0000, 32'h0,        32'hCAFE_F00D, 1, 1);
        doAccess("sz11",   1'b1, 2'b11, 1'b0, 32'h0000_0008, 32'h0BAD_CAFE, 32'h0,        0, 0, 32'h0000_0008, 2'b10, 4'b1111, 32'h0BAD_CAFE, 32'h0,        1, 1);

        // Misaligned word, then misaligned half: flagged, no request, no stall.
        mem_enM   = 1'b1;
        mem_sizeM = 2'b10;
        aluoutM   = 32'h0000_0002;
        #1;
        check("mis_w_aerr", {31'h0, addr_errM}, 32'h1);
        check("mis_w_req", {31'h0, data_req}, 32'h0);
        check("mis_w_stall", {31'h0, stallM}, 32'h0);
        @(negedge clk);
        mem_sizeM = 2'b01;
        aluoutM   = 32'h0000_0005;
        #1;
        check("mis_h_aerr", {31'h0, addr_errM}, 32'h1);
        check("mis_h_req", {31'h0, data_req}, 32'h0);
        @(negedge clk);
        idleInputs();
        #1;
        check("mis_clear", {31'h0, addr_errM}, 32'h0);
        @(negedge clk);

        // Reset during WAIT, then a stray data_ok afterwards.
        mem_enM      = 1'b1;
        mem_sizeM    = 2'b10;
        aluoutM      = 32'h0000_0020;
        data_rdata   = 32'hFEED_FACE;
        data_addr_ok = 1'b1;
        #1;
        check("rw_req", {31'h0, data_req}, 32'h1);
        @(negedge clk);
        data_addr_ok = 1'b0;
        #1;
        check("rw_wait_req", {31'h0, data_req}, 32'h0);
        check("rw_wait_stall", {31'h0, stallM}, 32'h1);
        rst     = 1'b0;
        mem_enM = 1'b0;
        @(negedge clk);
        rst          = 1'b1;
        data_data_ok = 1'b1;
        #1;
        check("rw_post_stall", {31'h0, stallM}, 32'h0);
        check("rw_post_rdata", readdataM, 32'h0);
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        check("rw_stray_rdata", readdataM, 32'h0);
        check("rw_stray_stall", {31'h0, stallM}, 32'h0);
        @(negedge clk);
        doAccess("after", 1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0, 32'h0BAD_F00D, 0, 0, 32'h0000_0030, 2'b10, 4'b0000, 32'h0, 32'h0BAD_F00D, 1, 1);

        check("sb_drained", sbQ.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_sram_bridge.md
DATA_SRAM_BRIDGE -- requirements
Module: data_sram_bridge

Interface
REQ-001 Parameter KSEG_MAP, default 1: when 1, addresses 0x8000_0000-0xBFFF_FFFF map to physical by clearing addr[31:29]; when 0, addresses pass through unchanged.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset; synchronous, active-low.
REQ-004 mem_enM  in  1  M-stage instruction is a load or store.
REQ-005 memwriteM  in  1  1 = store, 0 = load.
REQ-006 mem_sizeM  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-007 mem_signedM  in  1  load result is sign-extended (1) or zero-extended (0).
REQ-008 aluoutM  in  32  virtual byte address.
REQ-009 writedataM  in  32  store data, right-aligned.
REQ-010 readdataM  out  32  aligned, extended load result.
REQ-011 stallM  out  1  pipeline stall request while an access is incomplete.
REQ-012 addr_errM  out  1  misaligned access detected.
REQ-013 data_req, data_wr  out  1 each  bus request and write flag.
REQ-014 data_size  out  2  bus transfer size; same encoding as mem_sizeM.
REQ-015 data_addr  out  32  physical byte address.
REQ-016 data_wstrb  out  4  byte-lane write enables.
REQ-017 data_wdata  out  32  lane-replicated store data.
REQ-018 data_addr_ok, data_data_ok  in  1 each  bus request accepted; bus read or write completed.
REQ-019 data_rdata  in  32  bus read data, valid with data_data_ok.

Function
REQ-020 FSM states: IDLE, REQ, WAIT, DONE.
REQ-021 Misalignment: half with addr[0]=1, or word with addr[1:0]!=0, sets addr_errM=1 combinationally; in that case no bus request is made, stallM=0, and the state stays IDLE.
REQ-022 IDLE: when mem_enM=1 and the access is aligned, drive data_req=1 and stallM=1 combinationally.
  - addr_ok and data_ok both high -> DONE.
  - addr_ok only -> WAIT.
  - otherwise -> REQ.
REQ-023 REQ: hold data_req=1 with all bus outputs stable.
  - addr_ok and data_ok -> DONE.
  - addr_ok only -> WAIT.
REQ-024 WAIT: data_req=0, stallM=1; on data_ok -> DONE.
REQ-025 On each data_ok for a load, capture the aligned result in a 32-bit register.
REQ-026 DONE: stallM=0 and readdataM = captured register; unconditional -> IDLE.
  - DONE lasts exactly one cycle, so the access is never re-issued.
REQ-027 Minimum latency from an aligned request to stallM=0 is 1 cycle (IDLE with addr_ok and data_ok, then DONE).
REQ-028 data_ok received in IDLE or REQ-without-addr_ok is ignored.
REQ-029 Store lanes: byte -> wstrb = 1<<addr[1:0], wdata = {4{wd[7:0]}}.
  - half -> wstrb = addr[1] ? 1100 : 0011, wdata = {2{wd[15:0]}}.
  - word -> wstrb = 1111, wdata = wd.
  - For loads, wstrb = 0000.
REQ-030 Load extraction: select the byte or half at addr[1:0]/addr[1]; extend to 32 bits per mem_signedM.
REQ-031 When data_req=0, all bus outputs are 0.
REQ-032 stallM=0 whenever mem_enM=0 in IDLE.

Reset
REQ-033 When rst=0 at a clock edge: state <- IDLE and captured data <- 0; data_req, stallM and addr_errM then read 0.
REQ-034 Reset mid-access (REQ or WAIT) abandons the access; a later stray data_ok is ignored per REQ-028.

Structure
REQ-035 The shared definitions package holds the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the FSM state encoding.
REQ-036 One combinational sub-module, load_align (rdata, addr[1:0], size, signed -> result), performs the extraction of REQ-030.

Verification
REQ-037 Word load, addr 0x8000_0010, addr_ok and data_ok in the same cycle, rdata 0x1234_5678.
  - Required: data_addr = 0x0000_0010, stallM high for 1 cycle, then DONE with readdataM = 0x1234_5678.
REQ-038 Signed byte load at addr 0x...03, rdata 0x80FF_FF7F -> readdataM = 0xFFFF_FF80.
  - The same load unsigned -> 0x0000_0080.
REQ-039 Half store, wd 0x0000_ABCD, addr 0x...02, addr_ok delayed 3 cycles, data_ok 2 cycles later.
  - Required: data_req held for 4 cycles, wstrb = 1100, wdata = 0xABCD_ABCD, stallM high for 6 cycles.
REQ-040 Word load at addr 0x...02 -> addr_errM=1, data_req=0, stallM=0.
REQ-041 Reset asserted during WAIT, then data_ok pulsed after reset released.
  - Required: state IDLE, no DONE pulse, readdataM = 0.
